// File: rtl/regf_pkg.sv
// Shared types and default sizes for the register-file access master.
package regf_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_NREGS  = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        READ,
        RESP
    } regf_st_e;

endpackage

// File: rtl/regf_access_master_if.sv
// Request, response and register-file port bundle for regf_access_master.
interface regf_access_master_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs1;
    logic [ADDR_W-1:0] req_rs2;
    logic              req_wen;
    logic [ADDR_W-1:0] req_rd;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_d1;
    logic [DATA_W-1:0] rsp_d2;

    logic [ADDR_W-1:0] rf_re1;
    logic [ADDR_W-1:0] rf_re2;
    logic [ADDR_W-1:0] rf_w;
    logic [DATA_W-1:0] rf_da;
    logic              rf_we;
    logic [DATA_W-1:0] rf_d1;
    logic [DATA_W-1:0] rf_d2;

    modport master (
        input  req_valid, req_rs1, req_rs2, req_wen, req_rd, req_wdata,
        output req_ready,
        output rsp_valid, rsp_d1, rsp_d2,
        input  rsp_ready,
        output rf_re1, rf_re2, rf_w, rf_da, rf_we,
        input  rf_d1, rf_d2
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, req_wen, req_rd, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_d1, rsp_d2,
        output rsp_ready,
        input  rf_re1, rf_re2, rf_w, rf_da, rf_we,
        output rf_d1, rf_d2
    );

endinterface

// File: rtl/regf_clear_seq.sv
// Post-reset clear counter: walks every register address and flags the last one.
module regf_clear_seq
    import regf_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    localparam int unsigned     NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(NREGS - 1);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] clr_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            clr_cnt <= '0;
        end else if (en) begin
            clr_cnt <= clr_cnt + ONE;
        end
    end

    assign addr = clr_cnt[ADDR_W-1:0];
    assign done = (clr_cnt == LAST);

endmodule

// File: rtl/regf_access_master.sv
// Request-side controller for a 2R/1W register file: clears it after reset, then serves fetch/writeback requests.
// Optional macro REGF_R0_ZERO_EN makes register 0 read as zero and ignore writes.
module regf_access_master
    import regf_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                 Clk,
    input  logic                 Rst,
    regf_access_master_if.master bus
);

    regf_st_e state, state_nxt;

    logic [ADDR_W-1:0] cap_rs1, cap_rs2, cap_rd;
    logic              cap_wen;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] d1_q, d2_q;

    logic              clr_en, clr_done;
    logic [ADDR_W-1:0] clr_addr;

    logic              wr_allow;
    logic [DATA_W-1:0] rd1, rd2;

    regf_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear (
        .Clk (Clk),
        .Rst (Rst),
        .en  (clr_en),
        .addr(clr_addr),
        .done(clr_done)
    );

`ifdef REGF_R0_ZERO_EN
    assign wr_allow = (cap_rd != '0);
    assign rd1      = (cap_rs1 == '0) ? '0 : bus.rf_d1;
    assign rd2      = (cap_rs2 == '0) ? '0 : bus.rf_d2;
`else
    assign wr_allow = 1'b1;
    assign rd1      = bus.rf_d1;
    assign rd2      = bus.rf_d2;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cap_rs1   <= '0;
            cap_rs2   <= '0;
            cap_wen   <= 1'b0;
            cap_rd    <= '0;
            cap_wdata <= '0;
        end else if (state == IDLE && bus.req_valid) begin
            cap_rs1   <= bus.req_rs1;
            cap_rs2   <= bus.req_rs2;
            cap_wen   <= bus.req_wen;
            cap_rd    <= bus.req_rd;
            cap_wdata <= bus.req_wdata;
        end
    end

    // Operands are sampled at the same edge that commits the write, so reads see the old value.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            d1_q <= '0;
            d2_q <= '0;
        end else if (state == READ) begin
            d1_q <= rd1;
            d2_q <= rd2;
        end
    end

    always_comb begin
        state_nxt     = state;
        clr_en        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rf_we     = 1'b0;
        bus.rf_w      = cap_rd;
        bus.rf_da     = cap_wdata;
        unique case (state)
            INIT: begin
                clr_en    = 1'b1;
                bus.rf_we = 1'b1;
                bus.rf_w  = clr_addr;
                bus.rf_da = '0;
                if (clr_done) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                bus.rf_we = cap_wen & wr_allow;
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    assign bus.rf_re1 = cap_rs1;
    assign bus.rf_re2 = cap_rs2;
    assign bus.rsp_d1 = d1_q;
    assign bus.rsp_d2 = d2_q;

endmodule

// File: tb/tb_regf_access_master.sv
// Bench for regf_access_master: behavioural register file, architectural register model and directed scenarios.
module tb_regf_access_master;
    import regf_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 16;
`ifdef REGF_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    int total = 0;
    int bad   = 0;

    regf_access_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regf_access_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus.master)
    );

    always #5 Clk = ~Clk;

    // Register file the master drives; powers up with junk so the clear is observable.
    logic [DW-1:0] rf_mem [NR] = '{default: 16'hBAD0};
    always @(posedge Clk) if (bus.rf_we) rf_mem[bus.rf_w] <= bus.rf_da;
    assign bus.rf_d1 = rf_mem[bus.rf_re1];
    assign bus.rf_d2 = rf_mem[bus.rf_re2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: register contents plus in-order expected responses.
    logic [DW-1:0]   ref_regs [NR];
    logic [2*DW-1:0] expq [$];
    int unsigned     cyc = 0;
    int unsigned     rsp_cyc [$];

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Rst) begin
            expq.delete();
            for (int i = 0; i < NR; i++) ref_regs[i] <= '0;
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (expq.size() > 0) void'(expq.pop_front());
                rsp_cyc.push_back(cyc);
            end
            if (bus.req_valid && bus.req_ready) begin
                expq.push_back({(R0Z && bus.req_rs1 == 0) ? 16'h0 : ref_regs[bus.req_rs1],
                                (R0Z && bus.req_rs2 == 0) ? 16'h0 : ref_regs[bus.req_rs2]});
                if (bus.req_wen && !(R0Z && bus.req_rd == 0))
                    ref_regs[bus.req_rd] <= bus.req_wdata;
            end
        end
    end

    always @(negedge Clk) begin
        if (!Rst && bus.rsp_valid) begin
            if (expq.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check("rsp_d1", 32'(bus.rsp_d1), 32'(expq[0][2*DW-1:DW]));
                check("rsp_d2", 32'(bus.rsp_d2), 32'(expq[0][DW-1:0]));
            end
            check("ready_in_resp", 32'(bus.req_ready), 32'd0);
        end
    end

    task automatic check_init();
        for (int i = 0; i < NR; i++) begin
            @(negedge Clk);
            check("init_we", 32'(bus.rf_we), 32'd1);
            check("init_w", 32'(bus.rf_w), 32'(i));
            check("init_da", 32'(bus.rf_da), 32'd0);
            check("init_rdy", 32'(bus.req_ready), 32'd0);
        end
        @(negedge Clk);
        check("idle_rdy", 32'(bus.req_ready), 32'd1);
        check("idle_we", 32'(bus.rf_we), 32'd0);
        @(posedge Clk); #1;
    endtask

    task automatic send(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic wen,
                        input logic [AW-1:0] rd, input logic [DW-1:0] wdata);
        int n;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_wen   = wen;
        bus.req_rd    = rd;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        n = 0;
        @(negedge Clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("req_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge Clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [DW-1:0] d1, output logic [DW-1:0] d2);
        int n;
        n = 0;
        bus.rsp_ready = 1'b1;
        @(negedge Clk);
        while (!bus.rsp_valid && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        d1 = bus.rsp_d1;
        d2 = bus.rsp_d2;
        @(posedge Clk); #1;
    endtask

    task automatic xact(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic wen,
                        input logic [AW-1:0] rd, input logic [DW-1:0] wdata,
                        output logic [DW-1:0] d1, output logic [DW-1:0] d2);
        send(rs1, rs2, wen, rd, wdata);
        get_rsp(d1, d2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d1, d2;
        bus.req_valid = 1'b0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_wen   = 1'b0;
        bus.req_rd    = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // 1: reset values, full clear, read of cleared registers
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_d1", 32'(bus.rsp_d1), 32'd0);
        check("rst_rsp_d2", 32'(bus.rsp_d2), 32'd0);
        check("rst_re1", 32'(bus.rf_re1), 32'd0);
        check("rst_re2", 32'(bus.rf_re2), 32'd0);
        Rst = 1'b0;
        check_init();
        xact(4'd5, 4'd9, 1'b0, 4'd0, 16'h0, d1, d2);
        check("t1_d1", 32'(d1), 32'h0);
        check("t1_d2", 32'(d2), 32'h0);

        // 2: read-before-write on the same register
        xact(4'd3, 4'd3, 1'b1, 4'd3, 16'h00AB, d1, d2);
        check("t2_old_d1", 32'(d1), 32'h0);
        check("t2_old_d2", 32'(d2), 32'h0);
        xact(4'd3, 4'd3, 1'b0, 4'd0, 16'h0, d1, d2);
        check("t2_new_d1", 32'(d1), 32'h00AB);
        check("t2_new_d2", 32'(d2), 32'h00AB);

        // 3: latency and back-pressure
        bus.rsp_ready = 1'b0;
        send(4'd3, 4'd5, 1'b0, 4'd0, 16'h0);
        check("lat_read_valid", 32'(bus.rsp_valid), 32'd0);
        check("lat_read_ready", 32'(bus.req_ready), 32'd0);
        @(posedge Clk); #1;
        check("lat_resp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.req_rs1   = 4'd9;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_d1", 32'(bus.rsp_d1), 32'h00AB);
            check("bp_d2", 32'(bus.rsp_d2), 32'h0);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge Clk); #1;
        check("bp_released", 32'(bus.rsp_valid), 32'd0);

        // 4a: reset while in READ drops the pending write
        send(4'd7, 4'd7, 1'b1, 4'd7, 16'h7777);
        Rst = 1'b1;
        #1;
        check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rr_req_ready", 32'(bus.req_ready), 32'd0);
        check("rr_init_w", 32'(bus.rf_w), 32'd0);
        @(posedge Clk); #1;
        check("rr_no_write", 32'(rf_mem[7]), 32'h0);
        Rst = 1'b0;
        check_init();
        xact(4'd7, 4'd3, 1'b0, 4'd0, 16'h0, d1, d2);
        check("rr_d1", 32'(d1), 32'h0);
        check("rr_d2", 32'(d2), 32'h0);

        // 4b: reset while in RESP
        bus.rsp_ready = 1'b0;
        send(4'd3, 4'd7, 1'b0, 4'd0, 16'h0);
        @(posedge Clk); #1;
        check("rs_valid_before", 32'(bus.rsp_valid), 32'd1);
        Rst = 1'b1;
        #1;
        check("rs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rs_rsp_d1", 32'(bus.rsp_d1), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        bus.rsp_ready = 1'b1;
        check_init();

        // 5: register 0 handling
        send(4'd0, 4'd0, 1'b1, 4'd0, 16'h1234);
        check("r0_we_in_read", 32'(bus.rf_we), R0Z ? 32'd0 : 32'd1);
        get_rsp(d1, d2);
        xact(4'd0, 4'd3, 1'b0, 4'd0, 16'h0, d1, d2);
        check("r0_read", 32'(d1), R0Z ? 32'h0 : 32'h1234);

        // 6: back-to-back requests, one response every 3 cycles
        xact(4'd3, 4'd3, 1'b1, 4'd3, 16'h00AB, d1, d2);
        rsp_cyc.delete();
        send(4'd3, 4'd10, 1'b1, 4'd10, 16'h1010);
        send(4'd10, 4'd11, 1'b1, 4'd11, 16'h2222);
        send(4'd11, 4'd3, 1'b0, 4'd0, 16'h0);
        send(4'd10, 4'd0, 1'b0, 4'd0, 16'h0);
        repeat (4) @(posedge Clk);
        #1;
        check("b2b_count", 32'(rsp_cyc.size()), 32'd4);
        if (rsp_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("b2b_gap", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
        end
        xact(4'd10, 4'd11, 1'b0, 4'd0, 16'h0, d1, d2);
        check("b2b_final_d1", 32'(d1), 32'h1010);
        check("b2b_final_d2", 32'(d2), 32'h2222);

        repeat (2) @(posedge Clk);
        check("queue_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
